// File: rtl/count_display_scan_pkg.sv
`default_nettype none
// ============================================================================
//  count_display_scan_pkg
//  Shared 7-segment patterns, conversion FSM states and digit decoder.
//  Rev 1.0
// ============================================================================
package count_display_scan_pkg;

  // {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] C_SEG_0     = 7'h40;
  localparam logic [6:0] C_SEG_1     = 7'h79;
  localparam logic [6:0] C_SEG_2     = 7'h24;
  localparam logic [6:0] C_SEG_3     = 7'h30;
  localparam logic [6:0] C_SEG_4     = 7'h19;
  localparam logic [6:0] C_SEG_5     = 7'h12;
  localparam logic [6:0] C_SEG_6     = 7'h02;
  localparam logic [6:0] C_SEG_7     = 7'h78;
  localparam logic [6:0] C_SEG_8     = 7'h00;
  localparam logic [6:0] C_SEG_9     = 7'h10;
  localparam logic [6:0] C_SEG_U     = 7'h41;
  localparam logic [6:0] C_SEG_D     = 7'h21;
  localparam logic [6:0] C_SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } conv_state_t;

  function automatic logic [6:0] seg_of_digit(input logic [3:0] d);
    case (d)
      4'd0:    seg_of_digit = C_SEG_0;
      4'd1:    seg_of_digit = C_SEG_1;
      4'd2:    seg_of_digit = C_SEG_2;
      4'd3:    seg_of_digit = C_SEG_3;
      4'd4:    seg_of_digit = C_SEG_4;
      4'd5:    seg_of_digit = C_SEG_5;
      4'd6:    seg_of_digit = C_SEG_6;
      4'd7:    seg_of_digit = C_SEG_7;
      4'd8:    seg_of_digit = C_SEG_8;
      4'd9:    seg_of_digit = C_SEG_9;
      default: seg_of_digit = C_SEG_BLANK;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/count_display_scan_if.sv
`default_nettype none
// ============================================================================
//  count_display_scan_if
//  Count/direction inputs and multiplexed display outputs.
//  Rev 1.0
// ============================================================================
interface count_display_scan_if;
  logic [7:0] value;
  logic       UD;
  logic       En;
  logic [6:0] seg;
  logic [3:0] an;
  logic       busy;

  modport master (output value, output UD, output En,
                  input  seg,   input  an, input  busy);
  modport slave  (input  value, input  UD, input  En,
                  output seg,   output an, output busy);
endinterface
`default_nettype wire

// File: rtl/count_display_scan_bin8_to_bcd3.sv
`default_nettype none
// ============================================================================
//  bin8_to_bcd3
//  Sequential shift-add-3 binary to 3-digit BCD, one bit per clock.
//  Rev 1.0
// ============================================================================
module bin8_to_bcd3
  import count_display_scan_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        i_start,
  input  wire logic [7:0]  i_bin,
  output logic             o_busy,
  output logic             o_done,
  output logic [11:0]      o_bcd
);

  conv_state_t r_state;
  logic [19:0] r_sh;
  logic [2:0]  r_bitcnt;
  logic        r_busy;
  logic [19:0] w_adj;

  always_comb begin
    w_adj = r_sh;
    for (int k = 0; k < 3; k++) begin
      if (r_sh[8+4*k +: 4] >= 4'd5)
        w_adj[8+4*k +: 4] = r_sh[8+4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_sh     <= '0;
      r_bitcnt <= '0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_sh     <= {12'd0, i_bin};
            r_bitcnt <= '0;
            r_busy   <= 1'b1;
            r_state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_sh     <= {w_adj[18:0], 1'b0};
          r_bitcnt <= r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7)
            r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // done marks the LOAD cycle so the parent captures o_bcd on the same edge
  assign o_done = (r_state == ST_LOAD);
  assign o_busy = r_busy;
  assign o_bcd  = r_sh[19:8];

endmodule
`default_nettype wire

// File: rtl/count_display_scan.sv
`default_nettype none
// ============================================================================
//  count_display_scan
//  8-bit count to 4-digit multiplexed 7-segment display (000..255 + direction).
//  Rev 1.0
// ============================================================================
module count_display_scan
  import count_display_scan_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter bit LZB      = 1'b1
)(
  input  wire logic           clk,
  input  wire logic           reset,
  count_display_scan_if.slave bus
);

  localparam int              CNT_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [7:0]       r_snap;
  logic [3:0]       r_hund, r_tens, r_ones;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [6:0]       r_seg;
  logic [3:0]       r_an;
  logic             w_busy, w_done, w_start;
  logic [11:0]      w_bcd;
  logic [6:0]       w_seg_next;

  assign w_start = !w_busy && (bus.value != r_snap);

  bin8_to_bcd3 u_conv (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_start),
    .i_bin   (bus.value),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_bcd   (w_bcd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_snap <= '0;
      r_hund <= '0;
      r_tens <= '0;
      r_ones <= '0;
    end else begin
      if (w_start)
        r_snap <= bus.value;
      if (w_done) begin
        r_hund <= w_bcd[11:8];
        r_tens <= w_bcd[7:4];
        r_ones <= w_bcd[3:0];
      end
    end
  end

  always_comb begin
    w_seg_next = C_SEG_BLANK;
    case (r_idx)
      2'd0: w_seg_next = seg_of_digit(r_ones);
      2'd1: w_seg_next = (LZB && r_hund == 4'd0 && r_tens == 4'd0) ?
                         C_SEG_BLANK : seg_of_digit(r_tens);
      2'd2: w_seg_next = (LZB && r_hund == 4'd0) ? C_SEG_BLANK : seg_of_digit(r_hund);
      2'd3: w_seg_next = !bus.En ? C_SEG_BLANK : (bus.UD ? C_SEG_U : C_SEG_D);
      default: w_seg_next = C_SEG_BLANK;
    endcase
  end

  // r_idx names the digit lit at the next wrap, so digit 0 appears first after reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
      r_seg <= C_SEG_BLANK;
      r_an  <= 4'hF;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
      r_seg <= w_seg_next;
      r_an  <= ~(4'b0001 << r_idx);
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.seg  = r_seg;
  assign bus.an   = r_an;
  assign bus.busy = w_busy;

endmodule
`default_nettype wire
